// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// master = core plus data memory, slave = mem_access_unit.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_en;
   logic [31:0] mem_read_data;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_write_en
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_write_data, mem_write_en
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: byte-addressed byte/half/word requests onto a word-indexed
// memory, with lane extraction, sign/zero extension and sub-word read-modify-write.
module mem_access_unit #(
   parameter int WORD_ADDR_BITS = 10
) (
   input  logic             clk,
   input  logic             rst,
   mem_access_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam int         IDX_PAD = 32 - WORD_ADDR_BITS;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_BAD  = 2'b11;

   state_t                    state;
   logic [WORD_ADDR_BITS-1:0] idx_q;
   logic [1:0]                off_q;
   logic [1:0]                size_q;
   logic                      we_q;
   logic                      uns_q;
   logic [15:0]               wdata_q;
   logic [31:0]               wbuf_q;
   logic [31:0]               rdata_q;
   logic                      ready_q;
   logic                      valid_q;
   logic                      err_q;
   logic                      wen_q;

   logic                      req_err;
   logic [7:0]                byte_lane;
   logic [15:0]               half_lane;
   logic [31:0]               load_val;
   logic [31:0]               merged;

   always_comb begin
      req_err = (bus.req_size == SZ_BAD)
             || (bus.req_size == SZ_HALF && bus.req_addr[0])
             || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
             || (bus.req_addr[31:WORD_ADDR_BITS+2] != '0);
   end

   // NOTE: every output of this block is assigned on every path before any
   // conditional override, so no latch can be inferred.
   always_comb begin
      byte_lane = bus.mem_read_data[{off_q, 3'b000} +: 8];
      half_lane = bus.mem_read_data[{off_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_BYTE: load_val = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         SZ_HALF: load_val = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_val = bus.mem_read_data;
      endcase
      merged = bus.mem_read_data;
      if (size_q == SZ_BYTE) merged[{off_q, 3'b000} +: 8]    = wdata_q[7:0];
      else                   merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
         wbuf_q  <= '0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         wen_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         wen_q   <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               idx_q   <= bus.req_addr[WORD_ADDR_BITS+1:2];
               off_q   <= bus.req_addr[1:0];
               size_q  <= bus.req_size;
               we_q    <= bus.req_we;
               uns_q   <= bus.req_unsigned;
               wdata_q <= bus.req_wdata[15:0];
               ready_q <= 1'b0;
               rdata_q <= '0;
               err_q   <= req_err;
               if (req_err) begin
                  state   <= RESP;
                  valid_q <= 1'b1;
               end else if (bus.req_we && bus.req_size == SZ_WORD) begin
                  state  <= WR;
                  wbuf_q <= bus.req_wdata;
                  wen_q  <= 1'b1;
               end else begin
                  state <= RD;
               end
            end
            RD: begin
               if (we_q) begin
                  wbuf_q <= merged;
                  wen_q  <= 1'b1;
                  state  <= WR;
               end else begin
                  rdata_q <= load_val;
                  valid_q <= 1'b1;
                  state   <= RESP;
               end
            end
            WR: begin
               valid_q <= 1'b1;
               state   <= RESP;
            end
            RESP: begin
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Strobe and address are forced low while rst is asserted so that the reset
   // edge itself can never commit a pending write.
   assign bus.req_ready      = ready_q;
   assign bus.rsp_valid      = valid_q;
   assign bus.rsp_rdata      = rdata_q;
   assign bus.rsp_err        = err_q;
   assign bus.mem_write_data = wbuf_q;
   assign bus.mem_write_en   = wen_q & ~rst;
   assign bus.mem_address    = rst ? 32'h0 : {{IDX_PAD{1'b0}}, idx_q};
endmodule
